// File: rtl/ice_sl_arbiter_pkg.sv
// ============================================================================
// ice_sl_arbiter_pkg : shared state encodings and constants for the ICE slave
//                      bus arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ice_sl_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_HOLDOFF = 2'd2
    } arb_state_t;

    localparam logic [7:0] TIMEOUT_CNT_MAX = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/ice_sl_arbiter_rr_pick.sv
// ============================================================================
// ice_rr_pick : combinational winner selection, fixed priority or round-robin
//               (rotate, priority-encode, rotate back).
// Revision: 1.0
// ============================================================================
`default_nettype none

module ice_rr_pick #(
    parameter int NUM_DEV = 7,
    parameter int IDX_W   = 4
) (
    input  logic [NUM_DEV-1:0] i_elig,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    input  logic               i_rr_enable,
    output logic [NUM_DEV-1:0] o_winner,
    output logic [IDX_W-1:0]   o_winner_idx,
    output logic               o_any
);

    int                 w_start;
    int                 w_pos;
    int                 w_win;
    logic [NUM_DEV-1:0] w_rot;

    always_comb begin
        // Search starts just after the last owner; fixed priority starts at 0.
        w_start = 0;
        if (i_rr_enable && (int'(i_rr_ptr) < NUM_DEV - 1)) begin
            w_start = int'(i_rr_ptr) + 1;
        end

        w_rot = '0;
        for (int k = 0; k < NUM_DEV; k++) begin
            for (int j = 0; j < NUM_DEV; j++) begin
                if (j == ((w_start + k) % NUM_DEV)) begin
                    w_rot[k] = i_elig[j];
                end
            end
        end

        w_pos = 0;
        for (int k = NUM_DEV - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_pos = k;
            end
        end

        w_win        = (w_start + w_pos) % NUM_DEV;
        o_any        = |i_elig;
        o_winner_idx = IDX_W'(w_win);
        o_winner     = '0;
        for (int j = 0; j < NUM_DEV; j++) begin
            o_winner[j] = o_any && (j == w_win);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ice_sl_arbiter.sv
// ============================================================================
// ice_sl_arbiter : ICE slave output bus arbiter with selectable policy,
//                  one-cycle turnaround, watchdog quarantine and statistics.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ice_sl_arbiter
    import ice_sl_arbiter_pkg::*;
#(
    parameter int NUM_DEV   = 7,
    parameter int TIMEOUT_W = 16,
    parameter int IDX_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_DEV-1:0]   sl_arb_request,
    input  logic                 sl_latch_tail,
    input  logic                 rr_enable,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    output logic [NUM_DEV-1:0]   sl_arb_grant,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 timeout_evt,
    output logic [7:0]           timeout_count,
    output logic [NUM_DEV-1:0]   quarantine
);

    localparam logic [TIMEOUT_W-1:0] c_timer_one = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]     c_ptr_init  = IDX_W'(NUM_DEV - 1);

    arb_state_t           r_state;
    logic [NUM_DEV-1:0]   r_grant;
    logic                 r_grant_valid;
    logic [IDX_W-1:0]     r_grant_idx;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [TIMEOUT_W-1:0] r_timer;
    logic                 r_timeout_evt;
    logic [7:0]           r_timeout_count;
    logic [NUM_DEV-1:0]   r_quarantine;

    arb_state_t           w_state_nxt;
    logic [NUM_DEV-1:0]   w_grant_nxt;
    logic                 w_valid_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [IDX_W-1:0]     w_rr_ptr_nxt;
    logic [TIMEOUT_W-1:0] w_timer_nxt;
    logic                 w_evt_nxt;
    logic [7:0]           w_count_nxt;
    logic [NUM_DEV-1:0]   w_quar_nxt;

    logic [NUM_DEV-1:0]   w_elig;
    logic [NUM_DEV-1:0]   w_pick_onehot;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_pick_any;
    logic                 w_owner_req;
    logic                 w_timeout_hit;

    assign w_elig      = sl_arb_request & ~r_quarantine;
    assign w_owner_req = |(sl_arb_request & r_grant);

    // A release or a tail strobe in the final cycle always beats the watchdog.
    assign w_timeout_hit = (timeout_limit != '0)
                        && (r_timer == (timeout_limit - c_timer_one))
                        && !sl_latch_tail;

    ice_rr_pick #(
        .NUM_DEV (NUM_DEV),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_elig       (w_elig),
        .i_rr_ptr     (r_rr_ptr),
        .i_rr_enable  (rr_enable),
        .o_winner     (w_pick_onehot),
        .o_winner_idx (w_pick_idx),
        .o_any        (w_pick_any)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_valid_nxt  = r_grant_valid;
        w_idx_nxt    = r_grant_idx;
        w_rr_ptr_nxt = r_rr_ptr;
        w_timer_nxt  = r_timer;
        w_evt_nxt    = 1'b0;
        w_count_nxt  = r_timeout_count;
        w_quar_nxt   = r_quarantine & sl_arb_request;

        case (r_state)
            ARB_IDLE, ARB_HOLDOFF: begin
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
                if (w_pick_any) begin
                    w_state_nxt  = ARB_GRANT;
                    w_grant_nxt  = w_pick_onehot;
                    w_valid_nxt  = 1'b1;
                    w_idx_nxt    = w_pick_idx;
                    w_rr_ptr_nxt = w_pick_idx;
                    w_timer_nxt  = '0;
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end

            ARB_GRANT: begin
                if (!w_owner_req) begin
                    w_state_nxt = ARB_HOLDOFF;
                    w_grant_nxt = '0;
                    w_valid_nxt = 1'b0;
                end else if (w_timeout_hit) begin
                    w_state_nxt = ARB_HOLDOFF;
                    w_grant_nxt = '0;
                    w_valid_nxt = 1'b0;
                    w_evt_nxt   = 1'b1;
                    w_quar_nxt  = w_quar_nxt | r_grant;
                    if (r_timeout_count != TIMEOUT_CNT_MAX) begin
                        w_count_nxt = r_timeout_count + 8'd1;
                    end
                end else if (sl_latch_tail) begin
                    w_timer_nxt = '0;
                end else if (r_timer != '1) begin
                    w_timer_nxt = r_timer + c_timer_one;
                end
            end

            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ARB_IDLE;
            r_grant         <= '0;
            r_grant_valid   <= 1'b0;
            r_grant_idx     <= '0;
            r_rr_ptr        <= c_ptr_init;
            r_timer         <= '0;
            r_timeout_evt   <= 1'b0;
            r_timeout_count <= '0;
            r_quarantine    <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_grant         <= w_grant_nxt;
            r_grant_valid   <= w_valid_nxt;
            r_grant_idx     <= w_idx_nxt;
            r_rr_ptr        <= w_rr_ptr_nxt;
            r_timer         <= w_timer_nxt;
            r_timeout_evt   <= w_evt_nxt;
            r_timeout_count <= w_count_nxt;
            r_quarantine    <= w_quar_nxt;
        end
    end

    assign sl_arb_grant  = r_grant;
    assign grant_valid   = r_grant_valid;
    assign grant_idx     = r_grant_idx;
    assign timeout_evt   = r_timeout_evt;
    assign timeout_count = r_timeout_count;
    assign quarantine    = r_quarantine;

endmodule

`default_nettype wire

// File: tb/tb_ice_sl_arbiter.sv
// ============================================================================
// tb_ice_sl_arbiter : directed table-driven bench for ice_sl_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ice_sl_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  req;
    logic        tail;
    logic        rr;
    logic [15:0] limit;
    logic [6:0]  grant;
    logic        valid;
    logic [3:0]  idx;
    logic        evt;
    logic [7:0]  tcount;
    logic [6:0]  quar;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [6:0] req;
        logic       rr;
        logic [6:0] exp_grant;
        logic [3:0] exp_idx;
    } vec_t;

    vec_t vecs[$];

    ice_sl_arbiter #(
        .NUM_DEV   (7),
        .TIMEOUT_W (16),
        .IDX_W     (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sl_arb_request (req),
        .sl_latch_tail  (tail),
        .rr_enable      (rr),
        .timeout_limit  (limit),
        .sl_arb_grant   (grant),
        .grant_valid    (valid),
        .grant_idx      (idx),
        .timeout_evt    (evt),
        .timeout_count  (tcount),
        .quarantine     (quar)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [6:0] r, input logic m, input logic [6:0] g, input logic [3:0] i);
        vec_t v;
        v.req = r; v.rr = m; v.exp_grant = g; v.exp_idx = i;
        vecs.push_back(v);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n_evt;
        int n_bad;

        // Round-robin: 0,1,6,0,1 with each owner dropping for one cycle after 4 grant cycles
        add(7'b1000011, 1, 7'b0000001, 0); add(7'b1000011, 1, 7'b0000001, 0);
        add(7'b1000011, 1, 7'b0000001, 0); add(7'b1000011, 1, 7'b0000001, 0);
        add(7'b1000010, 1, 7'b0000000, 0);
        add(7'b1000011, 1, 7'b0000010, 1); add(7'b1000011, 1, 7'b0000010, 1);
        add(7'b1000011, 1, 7'b0000010, 1); add(7'b1000011, 1, 7'b0000010, 1);
        add(7'b1000001, 1, 7'b0000000, 1);
        add(7'b1000011, 1, 7'b1000000, 6); add(7'b1000011, 1, 7'b1000000, 6);
        add(7'b1000011, 1, 7'b1000000, 6); add(7'b1000011, 1, 7'b1000000, 6);
        add(7'b0000011, 1, 7'b0000000, 6);
        add(7'b1000011, 1, 7'b0000001, 0); add(7'b1000011, 1, 7'b0000001, 0);
        add(7'b1000011, 1, 7'b0000001, 0); add(7'b1000011, 1, 7'b0000001, 0);
        add(7'b1000010, 1, 7'b0000000, 0);
        add(7'b1000011, 1, 7'b0000010, 1);
        add(7'b0000000, 1, 7'b0000000, 1);
        add(7'b0000000, 1, 7'b0000000, 1);
        // Fixed priority
        add(7'b0100110, 0, 7'b0000010, 1); add(7'b0100110, 0, 7'b0000010, 1);
        add(7'b0100100, 0, 7'b0000000, 1);
        add(7'b0100100, 0, 7'b0000100, 2); add(7'b0100100, 0, 7'b0000100, 2);
        add(7'b0100000, 0, 7'b0000000, 2);
        add(7'b0100000, 0, 7'b0100000, 5);
        add(7'b0000000, 0, 7'b0000000, 5);
        add(7'b0000000, 0, 7'b0000000, 5);

        reset = 1'b1; req = '0; tail = 1'b0; rr = 1'b0; limit = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc();
        chk("rst_grant", grant, 0);
        chk("rst_valid", valid, 0);
        chk("rst_idx",   idx,   0);
        chk("rst_evt",   evt,   0);
        chk("rst_count", tcount, 0);
        chk("rst_quar",  quar,  0);

        for (int i = 0; i < vecs.size(); i++) begin
            req = vecs[i].req;
            rr  = vecs[i].rr;
            cyc();
            chk($sformatf("vec%0d_grant", i), grant, vecs[i].exp_grant);
            chk($sformatf("vec%0d_valid", i), valid, (vecs[i].exp_grant != 0));
            chk($sformatf("vec%0d_idx", i),   idx,   vecs[i].exp_idx);
            chk($sformatf("vec%0d_evt", i),   evt,   0);
        end

        // Watchdog: channel 5 stalls for 10 grant cycles
        rr = 1'b0; limit = 16'd10; req = 7'b0100000;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            chk($sformatf("wd_hold%0d", c), {evt, grant}, {1'b0, 7'b0100000});
        end
        cyc();
        chk("wd_grant_drop", grant, 0);
        chk("wd_evt",        evt,   1);
        chk("wd_count",      tcount, 1);
        chk("wd_quar",       quar,  7'b0100000);
        cyc();
        chk("wd_evt_pulse", evt, 0);
        cyc();
        chk("wd_no_regrant", grant, 0);
        req = '0;
        cyc();
        chk("wd_quar_clear", quar, 0);
        req = 7'b0100000;
        cyc();
        chk("wd_regrant", grant, 7'b0100000);
        req = '0;
        cyc(); cyc();

        // Progress: tail every 8 cycles keeps the grant alive
        req = 7'b0001000;
        cyc();
        n_bad = 0;
        for (int c = 0; c < 100; c++) begin
            tail = (c % 8 == 7);
            cyc();
            if (grant !== 7'b0001000 || evt !== 1'b0) n_bad++;
        end
        tail = 1'b0;
        chk("prog_bad_cycles", n_bad, 0);
        chk("prog_count", tcount, 1);
        req = '0;
        cyc(); cyc();

        // Owner releases in the timeout cycle
        req = 7'b0000100;
        cyc();
        repeat (9) cyc();
        req = '0;
        cyc();
        chk("rel_evt",   evt,   0);
        chk("rel_grant", grant, 0);
        chk("rel_quar",  quar,  0);
        chk("rel_count", tcount, 1);
        cyc();

        // Tail in the timeout cycle suppresses it; then a smaller limit bites at once
        req = 7'b0000100;
        cyc();
        repeat (9) cyc();
        tail = 1'b1;
        cyc();
        tail = 1'b0;
        chk("tail_sup_grant", grant, 7'b0000100);
        chk("tail_sup_evt",   evt,   0);
        limit = 16'd1;
        cyc();
        chk("lim_evt",   evt,   1);
        chk("lim_count", tcount, 2);
        chk("lim_quar",  quar,  7'b0000100);
        req = '0;
        cyc(); cyc();
        chk("lim_quar_clear", quar, 0);

        // Watchdog disabled over a long hold
        limit = '0; req = 7'b0010000;
        cyc();
        n_evt = 0;
        for (int c = 0; c < 70000; c++) begin
            cyc();
            if (evt) n_evt++;
        end
        chk("long_evt",   n_evt, 0);
        chk("long_grant", grant, 7'b0010000);
        chk("long_timer", dut.r_timer, 16'hFFFF);

        // Asynchronous reset mid-grant
        #3;
        reset = 1'b1;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_valid", valid, 0);
        chk("arst_idx",   idx,   0);
        chk("arst_count", tcount, 0);
        chk("arst_evt",   evt,   0);
        @(negedge clk);
        reset = 1'b0;
        req = 7'b1010000; rr = 1'b1;
        cyc();
        chk("post_rst_grant", grant, 7'b0010000);
        chk("post_rst_idx",   idx,   4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
